// File: rtl/round_ctrl_pkg.sv
// Shared types and defaults for the switch-game round sequencer.
// Phase encodings are visible on the phase output, so they are fixed values.
// Holds the default timing and scoring constants.
package round_ctrl_pkg;

    localparam int PHASE_W = 2;
    localparam int SECS_W  = 6;

    localparam int DEF_ROUND_SECS  = 15;
    localparam int DEF_BREAK_SECS  = 5;
    localparam int DEF_BASE_POINTS = 2;

    typedef enum logic [PHASE_W-1:0] {
        IDLE      = 2'd0,
        ROUND     = 2'd1,
        BREAK     = 2'd2,
        GAME_OVER = 2'd3
    } phase_e;

endpackage

// File: rtl/round_controller_if.sv
// Player inputs and status outputs of the round sequencer, bundled in one interface.
// master: the sequencer. It samples start_btn/is_correct and drives the status outputs.
// slave: the surrounding game logic (checker, prompt and display stages).
interface round_controller_if #(
    parameter int SCORE_W = 10,
    parameter int ROUND_W = 7
);
    import round_ctrl_pkg::*;

    logic                start_btn;
    logic                is_correct;
    logic                prompt_flag;
    logic [PHASE_W-1:0]  phase;
    logic [SECS_W-1:0]   secs_left;
    logic [ROUND_W-1:0]  round_num;
    logic [SCORE_W-1:0]  score;
    logic                game_over;

    modport master (
        input  start_btn, is_correct,
        output prompt_flag, phase, secs_left, round_num, score, game_over
    );

    modport slave (
        output start_btn, is_correct,
        input  prompt_flag, phase, secs_left, round_num, score, game_over
    );

endinterface

// File: rtl/score_accumulator.sv
// Score and passed-round bookkeeping for the round sequencer.
// Latency: score/round_num update on the tick after pass_i; clr_i zeroes them on the next tick.
// Backpressure: none. One pass is accepted per tick.
// Ports: clk_i, rst_i (async, active-high), pass_i, clr_i, score_o, round_num_o.
// Macro SCORE_DOUBLING_EN: points = BASE_POINTS << level, with level stepping every
// ROUNDS_PER_LEVEL passes (cap 7). Without the macro, every pass earns BASE_POINTS.
module score_accumulator #(
`ifdef SCORE_DOUBLING_EN
    parameter int ROUNDS_PER_LEVEL = 5,
`endif
    parameter int BASE_POINTS = 2,
    parameter int SCORE_W     = 10,
    parameter int ROUND_W     = 7
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pass_i,
    input  logic               clr_i,
    output logic [SCORE_W-1:0] score_o,
    output logic [ROUND_W-1:0] round_num_o
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [ROUND_W-1:0] ROUND_MAX = '1;

    logic [SCORE_W-1:0] score_q, score_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [SCORE_W-1:0] points;
    logic [SCORE_W:0]   sum;

`ifdef SCORE_DOUBLING_EN
    localparam int             MOD_W     = (ROUNDS_PER_LEVEL > 1) ? $clog2(ROUNDS_PER_LEVEL) : 1;
    localparam logic [MOD_W-1:0] MOD_LAST = MOD_W'(ROUNDS_PER_LEVEL - 1);
    localparam logic [2:0]     LEVEL_MAX = 3'd7;
    // Wide enough for any 32-bit base shifted by the maximum level.
    localparam int             PTS_W     = 40;

    logic [MOD_W-1:0] mod_q, mod_d;
    logic [2:0]       level_q, level_d;
    logic [PTS_W-1:0] points_wide;

    // Shifted points are clamped to the score range before the add, so a large
    // level on a narrow score can never wrap to a small value.
    always_comb begin
        points_wide = PTS_W'(BASE_POINTS) << level_q;
        if (points_wide > PTS_W'(SCORE_MAX)) begin
            points = SCORE_MAX;
        end else begin
            points = points_wide[SCORE_W-1:0];
        end
    end

    // mod counter counts passes within a level; level steps when it wraps.
    always_comb begin
        mod_d   = mod_q;
        level_d = level_q;
        if (clr_i) begin
            mod_d   = '0;
            level_d = '0;
        end else if (pass_i) begin
            if (mod_q == MOD_LAST) begin
                mod_d = '0;
                if (level_q != LEVEL_MAX) begin
                    level_d = level_q + 3'd1;
                end
            end else begin
                mod_d = mod_q + MOD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mod_q   <= '0;
            level_q <= '0;
        end else begin
            mod_q   <= mod_d;
            level_q <= level_d;
        end
    end
`else
    assign points = SCORE_W'(BASE_POINTS);
`endif

    // One extra bit catches the carry out; a carry means saturate.
    always_comb begin
        sum     = {1'b0, score_q} + {1'b0, points};
        score_d = score_q;
        round_d = round_q;
        if (clr_i) begin
            score_d = '0;
            round_d = '0;
        end else if (pass_i) begin
            score_d = sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
            if (round_q != ROUND_MAX) begin
                round_d = round_q + ROUND_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            score_q <= '0;
            round_q <= '0;
        end else begin
            score_q <= score_d;
            round_q <= round_d;
        end
    end

    assign score_o     = score_q;
    assign round_num_o = round_q;

endmodule

// File: rtl/round_controller.sv
// Switch-game sequencer: IDLE -> ROUND/BREAK cycles -> GAME_OVER, with countdown and score.
// Latency: all outputs are registered and change one clk1Hz tick after the deciding input sample.
// Backpressure: none. start_btn/is_correct are sampled every tick with no handshake.
// Ports: clk1Hz, reset_btn (async, active-high), bus (round_controller_if.master).
// Macro SCORE_DOUBLING_EN enables level-based score doubling in score_accumulator.
module round_controller
    import round_ctrl_pkg::*;
#(
    parameter int ROUND_SECS       = DEF_ROUND_SECS,
    parameter int BREAK_SECS       = DEF_BREAK_SECS,
`ifdef SCORE_DOUBLING_EN
    parameter int ROUNDS_PER_LEVEL = 5,
`endif
    parameter int BASE_POINTS      = DEF_BASE_POINTS,
    parameter int SCORE_W          = 10,
    parameter int ROUND_W          = 7
) (
    input  logic               clk1Hz,
    input  logic               reset_btn,
    round_controller_if.master bus
);

    localparam logic [SECS_W-1:0] ROUND_SECS_V = SECS_W'(ROUND_SECS);
    localparam logic [SECS_W-1:0] BREAK_SECS_V = SECS_W'(BREAK_SECS);
    localparam logic [SECS_W-1:0] SECS_ONE     = SECS_W'(1);

    phase_e             phase_q, phase_d;
    logic [SECS_W-1:0]  secs_q, secs_d;
    logic               armed_q, armed_d;
    logic               prompt_q, prompt_d;

    logic               pass_w;
    logic               start_w;

    // armed blocks a pass until is_correct has been seen low in this round;
    // the level may still be high from the previous round's answer.
    assign pass_w  = (phase_q == ROUND) && armed_q && bus.is_correct;
    assign start_w = ((phase_q == IDLE) || (phase_q == GAME_OVER)) && bus.start_btn;

    always_ff @(posedge clk1Hz or posedge reset_btn) begin
        if (reset_btn) begin
            phase_q  <= IDLE;
            secs_q   <= '0;
            armed_q  <= 1'b0;
            prompt_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            secs_q   <= secs_d;
            armed_q  <= armed_d;
            prompt_q <= prompt_d;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        secs_d   = secs_q;
        armed_d  = armed_q;
        prompt_d = 1'b0;
        case (phase_q)
            IDLE, GAME_OVER: begin
                if (start_w) begin
                    phase_d  = ROUND;
                    secs_d   = ROUND_SECS_V;
                    armed_d  = 1'b0;
                    prompt_d = 1'b1;
                end
            end
            ROUND: begin
                // Pass is checked first so a fix on the last second still counts.
                if (pass_w) begin
                    phase_d = BREAK;
                    secs_d  = BREAK_SECS_V;
                end else if (secs_q == SECS_ONE) begin
                    phase_d = GAME_OVER;
                    secs_d  = '0;
                end else begin
                    secs_d = secs_q - SECS_ONE;
                    if (!bus.is_correct) begin
                        armed_d = 1'b1;
                    end
                end
            end
            BREAK: begin
                if (secs_q == SECS_ONE) begin
                    phase_d  = ROUND;
                    secs_d   = ROUND_SECS_V;
                    armed_d  = 1'b0;
                    prompt_d = 1'b1;
                end else begin
                    secs_d = secs_q - SECS_ONE;
                end
            end
            default: begin
                phase_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.prompt_flag = prompt_q;
        bus.phase       = phase_q;
        bus.secs_left   = secs_q;
        bus.game_over   = (phase_q == GAME_OVER);
    end

    score_accumulator #(
`ifdef SCORE_DOUBLING_EN
        .ROUNDS_PER_LEVEL (ROUNDS_PER_LEVEL),
`endif
        .BASE_POINTS      (BASE_POINTS),
        .SCORE_W          (SCORE_W),
        .ROUND_W          (ROUND_W)
    ) u_score (
        .clk_i       (clk1Hz),
        .rst_i       (reset_btn),
        .pass_i      (pass_w),
        .clr_i       (start_w),
        .score_o     (bus.score),
        .round_num_o (bus.round_num)
    );

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: a directed vector table, hand sequences, and random play
// checked against a rule-level game model. Two DUTs share the stimulus: the default
// 10-bit score and a 4-bit score for saturation.
module tb_round_controller;
    import round_ctrl_pkg::*;

    logic clk1Hz = 1'b0;
    logic reset_btn;
    logic start_btn;
    logic is_correct;

    always #5 clk1Hz = ~clk1Hz;

    round_controller_if                bus_l ();
    round_controller_if #(.SCORE_W(4)) bus_s ();

    assign bus_l.start_btn  = start_btn;
    assign bus_l.is_correct = is_correct;
    assign bus_s.start_btn  = start_btn;
    assign bus_s.is_correct = is_correct;

    round_controller u_dut (
        .clk1Hz    (clk1Hz),
        .reset_btn (reset_btn),
        .bus       (bus_l.master)
    );

    round_controller #(.SCORE_W(4)) u_dut_w4 (
        .clk1Hz    (clk1Hz),
        .reset_btn (reset_btn),
        .bus       (bus_s.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- game model ----------------
    int m_phase;   // 0 idle, 1 round, 2 break, 3 game over
    int m_secs;
    int m_passes;  // passes since the current game started
    bit m_armed;
    bit m_prompt;

    function automatic int points_for(input int k);
        int lvl;
`ifdef SCORE_DOUBLING_EN
        lvl = (k - 1) / 5;
        if (lvl > 7) lvl = 7;
`else
        lvl = 0;
`endif
        return 2 << lvl;
    endfunction

    function automatic int score_of(input int passes, input int w);
        int cap;
        int s;
        cap = (1 << w) - 1;
        s   = 0;
        for (int k = 1; k <= passes; k++) begin
            s += points_for(k);
            if (s > cap) s = cap;
        end
        return s;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_secs = 0; m_passes = 0; m_armed = 0; m_prompt = 0;
    endtask

    task automatic model_step(input bit st, input bit ic);
        m_prompt = 0;
        if (m_phase == 0 || m_phase == 3) begin
            if (st) begin
                m_phase = 1; m_secs = 15; m_prompt = 1; m_armed = 0; m_passes = 0;
            end
        end else if (m_phase == 1) begin
            if (m_armed && ic) begin
                m_passes++; m_phase = 2; m_secs = 5;
            end else if (m_secs == 1) begin
                m_phase = 3; m_secs = 0;
            end else begin
                m_secs--;
                if (!ic) m_armed = 1;
            end
        end else begin
            if (m_secs == 1) begin
                m_phase = 1; m_secs = 15; m_prompt = 1; m_armed = 0;
            end else begin
                m_secs--;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        int rn;
        rn = (m_passes > 127) ? 127 : m_passes;
        check({tag, ".phase"},     bus_l.phase,       m_phase);
        check({tag, ".secs"},      bus_l.secs_left,   m_secs);
        check({tag, ".prompt"},    bus_l.prompt_flag, m_prompt);
        check({tag, ".game_over"}, bus_l.game_over,   m_phase == 3);
        check({tag, ".round"},     bus_l.round_num,   rn);
        check({tag, ".score"},     bus_l.score,       score_of(m_passes, 10));
        check({tag, ".score_w4"},  bus_s.score,       score_of(m_passes, 4));
        check({tag, ".phase_w4"},  bus_s.phase,       m_phase);
    endtask

    // Called just after a falling edge; drives, clocks, then samples at the next falling edge.
    task automatic tick(input bit st, input bit ic, input string tag);
        start_btn  = st;
        is_correct = ic;
        @(posedge clk1Hz);
        model_step(st, ic);
        @(negedge clk1Hz);
        compare_model(tag);
    endtask

    // Reset pulse placed between edges; outputs must clear before any clock edge.
    task automatic async_reset(input string tag);
        start_btn  = 1'b0;
        is_correct = 1'b0;
        #2 reset_btn = 1'b1;
        #1;
        check({tag, ".phase"},     bus_l.phase,       0);
        check({tag, ".secs"},      bus_l.secs_left,   0);
        check({tag, ".prompt"},    bus_l.prompt_flag, 0);
        check({tag, ".game_over"}, bus_l.game_over,   0);
        check({tag, ".round"},     bus_l.round_num,   0);
        check({tag, ".score"},     bus_l.score,       0);
        check({tag, ".score_w4"},  bus_s.score,       0);
        model_reset();
        #1 reset_btn = 1'b0;
        @(negedge clk1Hz);
        compare_model({tag, ".after"});
    endtask

    typedef struct {
        bit st;
        bit ic;
        int ph;
        int secs;
        bit pr;
        int score;
        int rnd;
    } vec_t;

    vec_t vt [11];

`ifdef SCORE_DOUBLING_EN
    localparam int EXP7 = 18, EXP7_W4 = 15, EXP8 = 22;
`else
    localparam int EXP7 = 14, EXP7_W4 = 14, EXP8 = 16;
`endif

    initial begin
        // start, ignored stale 1, arm, pass, five break ticks, new round with stale 1
        vt[0]  = '{1'b1, 1'b0, 1, 15, 1'b1, 0, 0};
        vt[1]  = '{1'b0, 1'b1, 1, 14, 1'b0, 0, 0};
        vt[2]  = '{1'b0, 1'b0, 1, 13, 1'b0, 0, 0};
        vt[3]  = '{1'b0, 1'b1, 2,  5, 1'b0, 2, 1};
        vt[4]  = '{1'b0, 1'b1, 2,  4, 1'b0, 2, 1};
        vt[5]  = '{1'b0, 1'b1, 2,  3, 1'b0, 2, 1};
        vt[6]  = '{1'b0, 1'b1, 2,  2, 1'b0, 2, 1};
        vt[7]  = '{1'b0, 1'b1, 2,  1, 1'b0, 2, 1};
        vt[8]  = '{1'b0, 1'b1, 1, 15, 1'b1, 2, 1};
        vt[9]  = '{1'b0, 1'b1, 1, 14, 1'b0, 2, 1};
        vt[10] = '{1'b0, 1'b1, 1, 13, 1'b0, 2, 1};

        reset_btn  = 1'b1;
        start_btn  = 1'b0;
        is_correct = 1'b0;
        model_reset();
        @(negedge clk1Hz);
        @(negedge clk1Hz);
        check("reset.phase",     bus_l.phase,       0);
        check("reset.secs",      bus_l.secs_left,   0);
        check("reset.prompt",    bus_l.prompt_flag, 0);
        check("reset.score",     bus_l.score,       0);
        check("reset.round",     bus_l.round_num,   0);
        check("reset.game_over", bus_l.game_over,   0);
        reset_btn = 1'b0;
        tick(1'b0, 1'b0, "idle");

        for (int i = 0; i < 11; i++) begin
            tick(vt[i].st, vt[i].ic, $sformatf("vec%0d.model", i));
            check($sformatf("vec%0d.phase", i),  bus_l.phase,       vt[i].ph);
            check($sformatf("vec%0d.secs", i),   bus_l.secs_left,   vt[i].secs);
            check($sformatf("vec%0d.prompt", i), bus_l.prompt_flag, vt[i].pr);
            check($sformatf("vec%0d.score", i),  bus_l.score,       vt[i].score);
            check($sformatf("vec%0d.round", i),  bus_l.round_num,   vt[i].rnd);
        end

        // Table ends mid-ROUND: reset between clock edges.
        async_reset("midround_reset");

        // Eight passes: level scoring and 4-bit saturation.
        tick(1'b1, 1'b0, "start");
        for (int p = 1; p <= 8; p++) begin
            tick(1'b0, 1'b0, "arm");
            tick(1'b0, 1'b1, "pass");
            if (p == 7) begin
                check("pass7.score",    bus_l.score, EXP7);
                check("pass7.score_w4", bus_s.score, EXP7_W4);
            end
            if (p == 8) begin
                check("pass8.score",    bus_l.score,     EXP8);
                check("pass8.score_w4", bus_s.score,     15);
                check("pass8.round",    bus_l.round_num, 8);
            end
            for (int b = 0; b < 5; b++) tick(1'b0, 1'b0, "break");
            if (p == 1) begin
                check("break_end.phase",  bus_l.phase,       1);
                check("break_end.secs",   bus_l.secs_left,   15);
                check("break_end.prompt", bus_l.prompt_flag, 1);
            end
        end

        // Timeout: is_correct never low... held low, so armed but never passes.
        for (int t = 0; t < 14; t++) tick(1'b0, 1'b0, "countdown");
        check("last_sec.phase", bus_l.phase,     1);
        check("last_sec.secs",  bus_l.secs_left, 1);
        tick(1'b0, 1'b0, "timeout");
        check("timeout.phase",     bus_l.phase,     3);
        check("timeout.secs",      bus_l.secs_left, 0);
        check("timeout.game_over", bus_l.game_over, 1);
        check("timeout.score",     bus_l.score,     EXP8);
        tick(1'b0, 1'b1, "hold");
        check("hold.score", bus_l.score, EXP8);

        // Restart from GAME_OVER clears score and round count.
        tick(1'b1, 1'b0, "restart");
        check("restart.score",  bus_l.score,       0);
        check("restart.round",  bus_l.round_num,   0);
        check("restart.prompt", bus_l.prompt_flag, 1);

        // Pass on the final second beats the timeout.
        for (int t = 0; t < 14; t++) tick(1'b0, 1'b0, "to_last");
        tick(1'b0, 1'b1, "edge_pass");
        check("edge_pass.phase", bus_l.phase,     2);
        check("edge_pass.secs",  bus_l.secs_left, 5);
        check("edge_pass.score", bus_l.score,     2);

        // Random play against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset("rand_reset");
            end else begin
                tick($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
